// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU:
// opcodes, FSM states and the flag bundle.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_SRL  = 4'h5,
      OP_SLL  = 4'h6,
      OP_ROL  = 4'h7,
      OP_ROR  = 4'h8,
      OP_SRA  = 4'h9,
      OP_SLT  = 4'hA,
      OP_SLTU = 4'hB,
      OP_MUL  = 4'hC
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Issue-side and writeback-side handshake
// bundle of the pipelined ALU.
interface alu_pipe_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op_code;
   logic [SHW-1:0]   shift_amount;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             neg;
   logic             carry;
   logic             ovf;

   modport master (
      output in_valid, a, b, op_code,
      output shift_amount, out_ready,
      input  in_ready, out_valid, result,
      input  zero, neg, carry, ovf
   );

   modport slave (
      input  in_valid, a, b, op_code,
      input  shift_amount, out_ready,
      output in_ready, out_valid, result,
      output zero, neg, carry, ovf
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one
// multiplier bit per cycle, WIDTH steps.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST =
      SHW'(WIDTH - 1);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [SHW-1:0]   cnt_q;
   logic             busy_q;

   assign acc_d = mplier_q[0] ?
                  acc_q + mcand_q : acc_q;
   assign done_o    = busy_q && (cnt_q == LAST);
   assign product_o = acc_d;

   // Load operands on start, then step once per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done_o)
            busy_q <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides;
// MUL is handed to the iterative multiplier.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic rst_n,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] WL =
      (SHW + 1)'(WIDTH);

   alu_state_e       state_q;
   logic             vld_q;
   logic [WIDTH-1:0] res_q;
   alu_flags_t       flg_q;

   alu_op_e          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SHW-1:0]   sh;
   logic [SHW:0]     inv;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             accept;
   logic             is_mul;
   logic [WIDTH-1:0] res_d;
   logic             c_d;
   logic             o_d;
   alu_flags_t       flg_d;
   alu_flags_t       mflg;
   logic             mul_done;
   logic [WIDTH-1:0] mul_prod;

   assign op   = alu_op_e'(bus.op_code);
   assign a    = bus.a;
   assign b    = bus.b;
   assign sh   = bus.shift_amount;
   assign inv  = WL - {1'b0, sh};
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   assign bus.in_ready  = (state_q == IDLE) &&
                          (!vld_q || bus.out_ready);
   assign accept = bus.in_valid && bus.in_ready;
   assign is_mul = (op == OP_MUL);

   // Single-cycle datapath; MUL and reserved give 0
   always_comb begin
      res_d = '0;
      c_d   = 1'b0;
      o_d   = 1'b0;
      unique case (op)
         OP_ADD: begin
            res_d = sum[WIDTH-1:0];
            c_d   = sum[WIDTH];
            o_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_d = diff[WIDTH-1:0];
            c_d   = diff[WIDTH];
            o_d   = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  res_d = a & b;
         OP_OR:   res_d = a | b;
         OP_XOR:  res_d = a ^ b;
         OP_SRL:  res_d = a >> sh;
         OP_SLL:  res_d = a << sh;
         OP_ROL:  res_d = (a << sh) | (a >> inv);
         OP_ROR:  res_d = (a >> sh) | (a << inv);
         OP_SRA:  res_d = $signed(a) >>> sh;
         OP_SLT:  res_d = WIDTH'($signed(a) <
                                 $signed(b));
         OP_SLTU: res_d = WIDTH'(a < b);
         default: res_d = '0;
      endcase
   end

   assign flg_d = '{zero:  (res_d == '0),
                    neg:   res_d[WIDTH-1],
                    carry: c_d,
                    ovf:   o_d};
   assign mflg  = '{zero:  (mul_prod == '0),
                    neg:   mul_prod[WIDTH-1],
                    carry: 1'b0,
                    ovf:   1'b0};

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (accept && is_mul),
      .a_i       (a),
      .b_i       (b),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   // FSM and output register; drain and load may coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         if (bus.out_ready)
            vld_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q <= MUL;
                  end else begin
                     res_q <= res_d;
                     flg_q <= flg_d;
                     vld_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (mul_done) begin
                  res_q   <= mul_prod;
                  flg_q   <= mflg;
                  vld_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.result    = res_q;
   assign bus.zero      = flg_q.zero;
   assign bus.neg       = flg_q.neg;
   assign bus.carry     = flg_q.carry;
   assign bus.ovf       = flg_q.ovf;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=32
// and WIDTH=8 with hand-computed vectors.
module tb_alu_pipe;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   alu_pipe_if #(.WIDTH(32)) b32 ();
   alu_pipe_if #(.WIDTH(8))  b8 ();

   alu_pipe #(.WIDTH(32)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b32.slave)
   );

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic issue32(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [4:0] sh);
      int t;
      @(negedge clk);
      b32.in_valid     = 1'b1;
      b32.op_code      = op;
      b32.a            = a;
      b32.b            = b;
      b32.shift_amount = sh;
      t = 0;
      while (!b32.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (t >= 50) begin
         n_fail++;
         $display("FAIL issue32 timeout op=%0h", op);
      end
      @(posedge clk);
      #1;
      b32.in_valid = 1'b0;
   endtask

   task automatic issue8(input logic [3:0] op,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [2:0] sh);
      int t;
      @(negedge clk);
      b8.in_valid     = 1'b1;
      b8.op_code      = op;
      b8.a            = a;
      b8.b            = b;
      b8.shift_amount = sh;
      t = 0;
      while (!b8.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (t >= 50) begin
         n_fail++;
         $display("FAIL issue8 timeout op=%0h", op);
      end
      @(posedge clk);
      #1;
      b8.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_chk++;
      if (b32.out_valid !== 1'b0 ||
          b32.result !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_out got v=%b r=%h want 0",
                  b32.out_valid, b32.result);
      end
      n_chk++;
      if ({b32.zero, b32.neg, b32.carry, b32.ovf}
          !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 0000",
                  {b32.zero, b32.neg,
                   b32.carry, b32.ovf});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (b32.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 1",
                  b32.in_ready);
      end
   endtask

   task automatic test_add_sub();
      issue32(4'h0, 32'h7FFFFFFF, 32'h1, 5'd0);
      n_chk++;
      if (b32.out_valid !== 1'b1 ||
          b32.result !== 32'h80000000) begin
         n_fail++;
         $display("FAIL add_res got v=%b r=%h want 1 80000000",
                  b32.out_valid, b32.result);
      end
      n_chk++;
      if ({b32.zero, b32.neg, b32.carry, b32.ovf}
          !== 4'b0101) begin
         n_fail++;
         $display("FAIL add_flags got %b want 0101",
                  {b32.zero, b32.neg,
                   b32.carry, b32.ovf});
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (b32.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_drain got %b want 0",
                  b32.out_valid);
      end
      issue32(4'h1, 32'h0, 32'h1, 5'd0);
      n_chk++;
      if (b32.result !== 32'hFFFFFFFF ||
          {b32.zero, b32.neg, b32.carry, b32.ovf}
          !== 4'b0110) begin
         n_fail++;
         $display("FAIL sub got r=%h f=%b want ffffffff 0110",
                  b32.result,
                  {b32.zero, b32.neg,
                   b32.carry, b32.ovf});
      end
      issue32(4'hA, 32'hFFFFFFFF, 32'h1, 5'd0);
      n_chk++;
      if (b32.result !== 32'h1) begin
         n_fail++;
         $display("FAIL slt got %h want 1", b32.result);
      end
      issue32(4'hB, 32'hFFFFFFFF, 32'h1, 5'd0);
      n_chk++;
      if (b32.result !== 32'h0 || b32.zero !== 1'b1) begin
         n_fail++;
         $display("FAIL sltu got r=%h z=%b want 0 1",
                  b32.result, b32.zero);
      end
   endtask

   task automatic test_shift_logic();
      logic [3:0]  ops [8];
      logic [31:0] av  [8];
      logic [31:0] bv  [8];
      logic [4:0]  shv [8];
      logic [31:0] ex  [8];
      ops = '{4'h7, 4'h8, 4'h9, 4'h5,
              4'h6, 4'h7, 4'h4, 4'hD};
      av  = '{32'h80000001, 32'h80000001,
              32'h80000000, 32'h80000000,
              32'h00000001, 32'h12345678,
              32'hF0F0F0F0, 32'hFFFFFFFF};
      bv  = '{32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'hFF00FF00,
              32'hFFFFFFFF};
      shv = '{5'd1, 5'd1, 5'd4, 5'd4,
              5'd31, 5'd0, 5'd0, 5'd3};
      ex  = '{32'h00000003, 32'hC0000000,
              32'hF8000000, 32'h08000000,
              32'h80000000, 32'h12345678,
              32'h0FF00FF0, 32'h00000000};
      for (int i = 0; i < 8; i++) begin
         issue32(ops[i], av[i], bv[i], shv[i]);
         n_chk++;
         if (b32.result !== ex[i]) begin
            n_fail++;
            $display("FAIL shlog%0d op=%h got %h want %h",
                     i, ops[i], b32.result, ex[i]);
         end
      end
      n_chk++;
      if ({b32.zero, b32.neg, b32.carry, b32.ovf}
          !== 4'b1000) begin
         n_fail++;
         $display("FAIL reserved_flags got %b want 1000",
                  {b32.zero, b32.neg,
                   b32.carry, b32.ovf});
      end
   endtask

   task automatic test_mul();
      logic [31:0] ma [2];
      logic [31:0] mb [2];
      logic [31:0] mx [2];
      int n;
      int bad;
      ma = '{32'h00010000, 32'd7};
      mb = '{32'h00010000, 32'd6};
      mx = '{32'h0, 32'd42};
      for (int i = 0; i < 2; i++) begin
         issue32(4'hC, ma[i], mb[i], 5'd0);
         n = 0;
         bad = (b32.in_ready !== 1'b0) ? 1 : 0;
         while (b32.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (b32.out_valid !== 1'b1 &&
                b32.in_ready !== 1'b0)
               bad++;
         end
         n_chk++;
         if (n != 32) begin
            n_fail++;
            $display("FAIL mul%0d_lat got %0d want 32",
                     i, n);
         end
         n_chk++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL mul%0d_ready got %0d hi want 0",
                     i, bad);
         end
         n_chk++;
         if (b32.result !== mx[i] ||
             b32.zero !== (mx[i] == 0)) begin
            n_fail++;
            $display("FAIL mul%0d_res got %h z=%b want %h",
                     i, b32.result, b32.zero, mx[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      logic [31:0] ex;
      @(posedge clk);
      #1;
      b32.out_ready = 1'b0;
      issue32(4'h0, 32'd2, 32'd3, 5'd0);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (b32.result !== 32'd5 ||
             b32.out_valid !== 1'b1 ||
             b32.in_ready !== 1'b0 ||
             b32.zero !== 1'b0)
            bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold got %0d bad cycles want 0",
                  bad);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b32.out_ready = 1'b1;
         b32.in_valid  = 1'b1;
         b32.op_code   = 4'h0;
         b32.a         = 32'(i * 10);
         b32.b         = 32'(i + 1);
         @(posedge clk);
         #1;
         ex = 32'(i * 11 + 1);
         n_chk++;
         if (b32.result !== ex ||
             b32.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b%0d got v=%b r=%h want 1 %h",
                     i, b32.out_valid, b32.result, ex);
         end
      end
      b32.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_mul();
      int stale;
      issue32(4'hC, 32'd7, 32'd6, 5'd0);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (b32.out_valid !== 1'b0 ||
          b32.result !== 32'h0 ||
          {b32.zero, b32.neg, b32.carry, b32.ovf}
          !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_mul_out got v=%b r=%h want 0 0",
                  b32.out_valid, b32.result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (b32.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mul_ready got %b want 1",
                  b32.in_ready);
      end
      issue32(4'h0, 32'd2, 32'd3, 5'd0);
      n_chk++;
      if (b32.result !== 32'd5 ||
          b32.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_add got v=%b r=%h want 1 5",
                  b32.out_valid, b32.result);
      end
      stale = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (b32.out_valid !== 1'b0)
            stale++;
      end
      n_chk++;
      if (stale != 0) begin
         n_fail++;
         $display("FAIL rst_stale got %0d valids want 0",
                  stale);
      end
   endtask

   task automatic test_width8();
      logic [3:0] ops [6];
      logic [7:0] av  [6];
      logic [7:0] bv  [6];
      logic [2:0] shv [6];
      logic [7:0] ex  [6];
      logic [7:0] mx  [2];
      logic [7:0] ma  [2];
      logic [7:0] mb  [2];
      int n;
      ops = '{4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'h5};
      av  = '{8'h7F, 8'h00, 8'h81, 8'h81,
              8'h80, 8'h80};
      bv  = '{8'h01, 8'h01, 8'h0, 8'h0,
              8'h0, 8'h0};
      shv = '{3'd0, 3'd0, 3'd1, 3'd1,
              3'd4, 3'd4};
      ex  = '{8'h80, 8'hFF, 8'h03, 8'hC0,
              8'hF8, 8'h08};
      for (int i = 0; i < 6; i++) begin
         issue8(ops[i], av[i], bv[i], shv[i]);
         n_chk++;
         if (b8.result !== ex[i]) begin
            n_fail++;
            $display("FAIL w8_%0d op=%h got %h want %h",
                     i, ops[i], b8.result, ex[i]);
         end
         if (i == 0) begin
            n_chk++;
            if ({b8.neg, b8.carry, b8.ovf} !== 3'b101) begin
               n_fail++;
               $display("FAIL w8_add_flags got %b want 101",
                        {b8.neg, b8.carry, b8.ovf});
            end
         end
         if (i == 1) begin
            n_chk++;
            if ({b8.carry, b8.ovf} !== 2'b10) begin
               n_fail++;
               $display("FAIL w8_sub_flags got %b want 10",
                        {b8.carry, b8.ovf});
            end
         end
      end
      ma = '{8'd7, 8'h10};
      mb = '{8'd6, 8'h10};
      mx = '{8'd42, 8'h00};
      for (int i = 0; i < 2; i++) begin
         issue8(4'hC, ma[i], mb[i], 3'd0);
         n = 0;
         while (b8.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         n_chk++;
         if (n != 8 || b8.result !== mx[i] ||
             b8.zero !== (mx[i] == 0)) begin
            n_fail++;
            $display("FAIL w8_mul%0d got lat=%0d r=%h want 8 %h",
                     i, n, b8.result, mx[i]);
         end
      end
   endtask

   initial begin
      n_chk            = 0;
      n_fail           = 0;
      rst_n            = 1'b1;
      b32.in_valid     = 1'b0;
      b32.a            = '0;
      b32.b            = '0;
      b32.op_code      = '0;
      b32.shift_amount = '0;
      b32.out_ready    = 1'b1;
      b8.in_valid      = 1'b0;
      b8.a             = '0;
      b8.b             = '0;
      b8.op_code       = '0;
      b8.shift_amount  = '0;
      b8.out_ready     = 1'b1;
      test_reset();
      test_add_sub();
      test_shift_logic();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      test_width8();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
